mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the EX result, performs data-memory load/store through a req/ack handshake, and holds the MEM/WB register.
- Drives the memory-stage and writeback-stage forwarding buses that feed back into execute-stage operand resolution.
- Back-pressures upstream with a stall while a memory access is outstanding.

Parameters:
DBITS, 32, datapath and memory data/address width
REG_INDEX_BIT_WIDTH, 4, register index width

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
exValid  in  1  EX stage presents a valid instruction this cycle
exAluResult  in  DBITS  ALU result (effective address for memory ops)
exStoreData  in  DBITS  resolved rs2, store data
exDestRegno  in  REG_INDEX_BIT_WIDTH  destination register
exRegWrtEn  in  1  instruction writes a register
exMemRead  in  1  load
exMemWrite  in  1  store
stall  out  1  upstream must hold; EX inputs ignored this cycle
memLoadPending  out  1  M holds a valid load (hazard unit interlock)
memFwdValue  out  DBITS  M-stage ALU result
memFwdRegno  out  REG_INDEX_BIT_WIDTH  M-stage destination
memFwdWrtEn  out  1  M-stage forward valid
wbFwdValue  out  DBITS  W-stage writeback value; also regfile write data
wbFwdRegno  out  REG_INDEX_BIT_WIDTH  W-stage destination; also regfile write index
wbFwdWrtEn  out  1  W-stage write enable; also regfile write enable
dmemReq  out  1  memory request
dmemWe  out  1  request is a store
dmemAddr  out  DBITS  word-aligned byte address
dmemWdata  out  DBITS  store data
dmemAck  in  1  memory completes the request this cycle
dmemRdata  in  DBITS  load data, valid when dmemAck
misalignErr  out  1  one-cycle pulse when a memory op with address[1:0] != 0 is dropped

Behaviour:
- Reset (rstN low, asynchronous): M and W valid bits cleared, FSM to IDLE. All outputs 0.
- M register captures the ex* inputs on every rising edge when stall = 0. A bubble is captured when exValid = 0.
- Memory op: exMemRead or exMemWrite set. Both set at once is illegal; treat it as a load.
- FSM states:
  - IDLE to ACCESS: M captures a valid, aligned memory op.
  - ACCESS to ACCESS: dmemAck = 0.
  - ACCESS to IDLE: dmemAck = 1 and the next captured op is not a memory op.
  - ACCESS to ACCESS (back-to-back): dmemAck = 1 and the next captured op is a memory op.
- dmemReq = (state == ACCESS).
- dmemWe, dmemAddr and dmemWdata come from M and stay stable while dmemReq = 1.
- Handshake: the request completes on the edge where dmemReq and dmemAck are both 1. dmemAck may be combinational, giving a minimum 1-cycle access.
- dmemAck while dmemReq = 0 is ignored.
- stall = (state == ACCESS) & ~dmemAck.
- While stalled: M holds its contents, and W captures a bubble (wbFwdWrtEn = 0).
- Misaligned op (address[1:0] != 0):
  - No request issued; misalignErr pulses for the single cycle M holds the op.
  - The op proceeds to W as a bubble, so no register write occurs.
- W register captures on every edge:
  - wbFwdWrtEn = M.valid & M.regWrtEn & ~stall & ~misaligned.
  - wbFwdValue = dmemRdata for a load, M.aluResult otherwise.
  - wbFwdRegno = M.destRegno.
- Stores never write a register, regardless of exRegWrtEn.
- memFwdWrtEn = M.valid & M.regWrtEn & ~M.memRead. Load data is never forwarded from M.
- memLoadPending = M.valid & M.memRead. This lets the hazard unit insert a load-use bubble.
- Register index 0 receives no special treatment.
- Reset mid-access: the outstanding request is abandoned, dmemReq drops asynchronously, and a late dmemAck after reset is ignored.

Decomposition:
- Shared package: FSM state encodings (MEMST_IDLE, MEMST_ACCESS), the pipeline-register field layout, and an alignment-mask constant.
- One sub-module, mem_stage_pipe_reg: a parameterised register with async active-low reset, enable and bubble-insert. It is instantiated twice, for M and W.

Test Plan:
- ALU op: exAluResult = 0x1234, dest 3, regWrtEn -> next cycle memFwd = (0x1234, 3, 1); following cycle wbFwd = (0x1234, 3, 1).
- Load, ack after 3 cycles:
  - addr 0x40 -> dmemReq = 1 with addr 0x40 for 3 cycles, stall = 1 for 2 cycles, memFwdWrtEn = 0.
  - Then wbFwd = (dmemRdata 0xDEADBEEF, dest, 1) on the cycle after ack.
- Store with combinational ack: addr 0x80, data 0xCAFE -> one cycle of dmemReq = 1, dmemWe = 1, wdata 0xCAFE; stall = 0; wbFwdWrtEn = 0.
- Back-to-back loads 0x10 and 0x14, each acked immediately -> dmemReq stays high for 2 cycles with addr 0x10 then 0x14, with no idle gap.
- Misaligned load at 0x42 -> dmemReq = 0, misalignErr = 1 for one cycle, no register write.
- rstN asserted while in ACCESS -> all outputs 0 immediately; a later dmemAck produces no write.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, the M/W pipeline
// register layouts and the word-alignment helper.
package mem_stage_pkg;

    localparam int MS_DBITS = 32;
    localparam int MS_REGW  = 4;

    typedef enum logic {
        MEMST_IDLE   = 1'b0,
        MEMST_ACCESS = 1'b1
    } memst_e;

    // Low address bits that must be zero for a word access.
    localparam logic [MS_DBITS-1:0] ALIGN_MASK = 'h3;

    typedef struct packed {
        logic                valid;
        logic [MS_DBITS-1:0] aluResult;
        logic [MS_DBITS-1:0] storeData;
        logic [MS_REGW-1:0]  destRegno;
        logic                regWrtEn;
        logic                memRead;
        logic                memWrite;
    } mreg_t;

    typedef struct packed {
        logic                wrtEn;
        logic [MS_DBITS-1:0] value;
        logic [MS_REGW-1:0]  regno;
    } wreg_t;

    function automatic logic is_misaligned(input logic [MS_DBITS-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_stage_pipe_reg.sv
// Generic pipeline register with asynchronous active-low reset, load enable
// and bubble insertion (a bubble loads all-zero, clearing the valid bit).
module mem_stage_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    assign data_d = bubble_i ? '0 : d_i;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/M register, data-memory req/ack access FSM,
// MEM/WB register and the M/W forwarding buses back into execute.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DBITS               = MS_DBITS,
    parameter int REG_INDEX_BIT_WIDTH = MS_REGW
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           exValid,
    input  logic [DBITS-1:0]               exAluResult,
    input  logic [DBITS-1:0]               exStoreData,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] exDestRegno,
    input  logic                           exRegWrtEn,
    input  logic                           exMemRead,
    input  logic                           exMemWrite,
    output logic                           stall,
    output logic                           memLoadPending,
    output logic [DBITS-1:0]               memFwdValue,
    output logic [REG_INDEX_BIT_WIDTH-1:0] memFwdRegno,
    output logic                           memFwdWrtEn,
    output logic [DBITS-1:0]               wbFwdValue,
    output logic [REG_INDEX_BIT_WIDTH-1:0] wbFwdRegno,
    output logic                           wbFwdWrtEn,
    output logic                           dmemReq,
    output logic                           dmemWe,
    output logic [DBITS-1:0]               dmemAddr,
    output logic [DBITS-1:0]               dmemWdata,
    input  logic                           dmemAck,
    input  logic [DBITS-1:0]               dmemRdata,
    output logic                           misalignErr
);

    localparam int MW = $bits(mreg_t);
    localparam int WW = $bits(wreg_t);

    memst_e         state_q, state_d;
    mreg_t          m_d, m_q;
    wreg_t          w_d, w_q;
    logic [MW-1:0]  mBits;
    logic [WW-1:0]  wBits;

    logic exIsStore;
    logic exMemOp;
    logic exStartsAccess;
    logic mMemOp;
    logic mMisaligned;
    logic stallInt;
    logic wbWrite;

    // Both read and write set is treated as a load, so only a pure write is a store.
    assign exIsStore      = exMemWrite & ~exMemRead;
    assign exMemOp        = exMemRead | exMemWrite;
    assign exStartsAccess = exValid & exMemOp & ~is_misaligned(exAluResult);

    always_comb begin
        m_d           = '0;
        m_d.valid     = exValid;
        m_d.aluResult = exAluResult;
        m_d.storeData = exStoreData;
        m_d.destRegno = exDestRegno;
        m_d.regWrtEn  = exRegWrtEn & ~exIsStore;
        m_d.memRead   = exMemRead;
        m_d.memWrite  = exIsStore;
    end

    assign stallInt = (state_q == MEMST_ACCESS) & ~dmemAck;

    mem_stage_pipe_reg #(
        .WIDTH (MW)
    ) u_m_reg (
        .clk      (clk),
        .rstN     (rstN),
        .en_i     (~stallInt),
        .bubble_i (~exValid),
        .d_i      (m_d),
        .q_o      (mBits)
    );

    assign m_q         = mreg_t'(mBits);
    assign mMemOp      = m_q.memRead | m_q.memWrite;
    assign mMisaligned = m_q.valid & mMemOp & is_misaligned(m_q.aluResult);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= MEMST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACCESS persists while unacked, or when the op captured on the ack edge is itself an access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MEMST_IDLE: begin
                if (exStartsAccess) begin
                    state_d = MEMST_ACCESS;
                end
            end
            MEMST_ACCESS: begin
                if (dmemAck) begin
                    state_d = exStartsAccess ? MEMST_ACCESS : MEMST_IDLE;
                end
            end
            default: state_d = MEMST_IDLE;
        endcase
    end

    assign wbWrite = m_q.valid & m_q.regWrtEn & ~stallInt & ~mMisaligned;

    always_comb begin
        w_d       = '0;
        w_d.wrtEn = 1'b1;
        w_d.value = m_q.memRead ? dmemRdata : m_q.aluResult;
        w_d.regno = m_q.destRegno;
    end

    mem_stage_pipe_reg #(
        .WIDTH (WW)
    ) u_w_reg (
        .clk      (clk),
        .rstN     (rstN),
        .en_i     (1'b1),
        .bubble_i (~wbWrite),
        .d_i      (w_d),
        .q_o      (wBits)
    );

    assign w_q = wreg_t'(wBits);

    assign stall          = stallInt;
    assign dmemReq        = (state_q == MEMST_ACCESS);
    assign dmemWe         = dmemReq & m_q.memWrite;
    assign dmemAddr       = m_q.aluResult & ~ALIGN_MASK;
    assign dmemWdata      = m_q.storeData;
    assign misalignErr    = mMisaligned;

    assign memLoadPending = m_q.valid & m_q.memRead;
    assign memFwdValue    = m_q.aluResult;
    assign memFwdRegno    = m_q.destRegno;
    assign memFwdWrtEn    = m_q.valid & m_q.regWrtEn & ~m_q.memRead;

    assign wbFwdValue     = w_q.value;
    assign wbFwdRegno     = w_q.regno;
    assign wbFwdWrtEn     = w_q.wrtEn;

endmodule
